// File: rtl/iq_enq_alloc_pkg.sv
// Shared helpers for the issue-queue slot allocator: width derivation,
// population count and modular pointer arithmetic.
package iq_alloc_pkg;

    // Widest occupancy vector the popcount helper accepts.
    localparam int MAX_QUEUE_SIZE = 64;

    function automatic int clog2_of(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic int ptr_width(input int queue_size);
        return clog2_of(queue_size);
    endfunction

    function automatic int count_width(input int queue_size);
        return clog2_of(queue_size + 1);
    endfunction

    localparam int DEF_QUEUE_SIZE = 8;
    localparam int DEF_PTR_W      = ptr_width(DEF_QUEUE_SIZE);
    localparam int DEF_CNT_W      = count_width(DEF_QUEUE_SIZE);

    function automatic int unsigned popcount(input logic [MAX_QUEUE_SIZE-1:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < MAX_QUEUE_SIZE; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // a < m and b <= m; wraps by compare-and-subtract.
    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int unsigned s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // a < m and b <= m.
    function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int unsigned d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + m - b;
        end
        return d;
    endfunction

endpackage

// File: rtl/iq_enq_alloc_if.sv
// Dispatch-side bus of the issue-queue slot allocator.
interface iq_enq_alloc_if #(
    parameter int QUEUE_SIZE = 8,
    parameter int ENQ_WIDTH  = 2
);
    import iq_alloc_pkg::*;

    localparam int CNT_W = count_width(QUEUE_SIZE);

    logic [ENQ_WIDTH-1:0]            enq_req;
    logic                            enq_ready;
    logic [ENQ_WIDTH*QUEUE_SIZE-1:0] enq_slot_oh;
    logic [QUEUE_SIZE-1:0]           deq_release;
    logic                            flush;
    logic [QUEUE_SIZE-1:0]           flush_kill;
    logic [QUEUE_SIZE-1:0]           valid_vec;
    logic [QUEUE_SIZE-1:0]           head_oh;
    logic [CNT_W-1:0]                count;
    logic                            empty;
    logic                            full;

    modport master (
        output enq_req, deq_release, flush, flush_kill,
        input  enq_ready, enq_slot_oh, valid_vec, head_oh, count, empty, full
    );

    modport slave (
        input  enq_req, deq_release, flush, flush_kill,
        output enq_ready, enq_slot_oh, valid_vec, head_oh, count, empty, full
    );

endinterface

// File: rtl/iq_enq_alloc_chk.sv
// Protocol and consistency checks for the slot allocator.
module iq_enq_alloc_chk
    import iq_alloc_pkg::*;
#(
    parameter int QUEUE_SIZE = 8,
    parameter int ENQ_WIDTH  = 2,
    parameter bit IN_ORDER   = 1'b1,
    parameter int PTR_W      = 3,
    parameter int CNT_W      = 4
) (
    input logic                            clock,
    input logic                            reset,
    input logic [ENQ_WIDTH-1:0]            enq_req,
    input logic [ENQ_WIDTH*QUEUE_SIZE-1:0] enq_slot_oh,
    input logic [QUEUE_SIZE-1:0]           valid_vec,
    input logic [CNT_W-1:0]                count,
    input logic [QUEUE_SIZE-1:0]           deq_release,
    input logic                            flush,
    input logic [QUEUE_SIZE-1:0]           flush_kill,
    input logic [PTR_W-1:0]                head,
    input logic [PTR_W-1:0]                tail
);

    localparam int unsigned QS_U = QUEUE_SIZE;

    logic                  overlap_s;
    logic [QUEUE_SIZE-1:0] rel_run_s;
    logic [QUEUE_SIZE-1:0] kill_run_s;
    int unsigned           rel_n_s;
    int unsigned           kill_n_s;

    // Detect lane one-hots colliding with each other or with occupied slots
    always_comb begin
        logic [QUEUE_SIZE-1:0] seen;
        seen      = valid_vec;
        overlap_s = 1'b0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if ((enq_slot_oh[i*QUEUE_SIZE +: QUEUE_SIZE] & seen) != '0) begin
                overlap_s = 1'b1;
            end else begin
                overlap_s = overlap_s;
            end
            seen = seen | enq_slot_oh[i*QUEUE_SIZE +: QUEUE_SIZE];
        end
    end

    // Legal ring masks: release run from head, kill suffix ending at tail-1
    always_comb begin
        rel_n_s    = popcount(MAX_QUEUE_SIZE'(deq_release));
        kill_n_s   = popcount(MAX_QUEUE_SIZE'(flush_kill));
        rel_run_s  = '0;
        kill_run_s = '0;
        for (int k = 0; k < QUEUE_SIZE; k++) begin
            if (32'(k) < rel_n_s) begin
                rel_run_s = rel_run_s | (QUEUE_SIZE'(1) << mod_add(32'(head), 32'(k), QS_U));
            end else begin
                rel_run_s = rel_run_s;
            end
            if (32'(k) < kill_n_s) begin
                kill_run_s = kill_run_s | (QUEUE_SIZE'(1) << mod_sub(32'(tail), 32'(k) + 32'd1, QS_U));
            end else begin
                kill_run_s = kill_run_s;
            end
        end
    end

    a_count_matches: assert property (@(posedge clock) disable iff (reset)
        32'(count) == popcount(MAX_QUEUE_SIZE'(valid_vec)));

    a_req_compacted: assert property (@(posedge clock) disable iff (reset)
        ((enq_req + ENQ_WIDTH'(1)) & enq_req) == '0);

    a_release_valid: assert property (@(posedge clock) disable iff (reset)
        (deq_release & ~valid_vec) == '0);

    a_no_overlap: assert property (@(posedge clock) disable iff (reset) !overlap_s);

    generate
        if (IN_ORDER) begin : g_ring_checks
            a_release_run: assert property (@(posedge clock) disable iff (reset)
                deq_release == rel_run_s);
            a_kill_suffix: assert property (@(posedge clock) disable iff (reset)
                flush |-> (flush_kill == kill_run_s));
        end
    endgenerate

endmodule

// File: rtl/iq_enq_alloc_free_slot_pick.sv
// Returns the N lowest-index zero bits of busy as N separate one-hots,
// applying a find-first-one step repeatedly on the still-free slots.
module free_slot_pick #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic [WIDTH-1:0]   busy,
    output logic [N*WIDTH-1:0] pick_oh
);

    function automatic logic [WIDTH-1:0] find_first1(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    // Successive lowest-free selection; each pick is marked taken for the next lane
    always_comb begin
        logic [WIDTH-1:0] taken;
        logic [WIDTH-1:0] first;
        taken   = busy;
        first   = '0;
        pick_oh = '0;
        for (int n = 0; n < N; n++) begin
            first = find_first1(~taken);
            pick_oh[n*WIDTH +: WIDTH] = first;
            taken = taken | first;
        end
    end

endmodule

// File: rtl/iq_enq_alloc.sv
// Issue-queue slot allocator: multi-lane enqueue grant, ring or lowest-free
// slot assignment, occupancy bitmap/count and partial flush.
module iq_enq_alloc
    import iq_alloc_pkg::*;
#(
    parameter int QUEUE_SIZE = 8,
    parameter int ENQ_WIDTH  = 2,
    parameter bit IN_ORDER   = 1'b1
) (
    input logic           clock,
    input logic           reset,
    iq_enq_alloc_if.slave bus
);

    localparam int          PTR_W = ptr_width(QUEUE_SIZE);
    localparam int          CNT_W = count_width(QUEUE_SIZE);
    localparam int unsigned QS_U  = QUEUE_SIZE;

    logic [QUEUE_SIZE-1:0]           valid_r;
    logic [PTR_W-1:0]                head_r;
    logic [PTR_W-1:0]                tail_r;
    logic [CNT_W-1:0]                count_r;

    logic [CNT_W-1:0]                free_s;
    logic                            enq_ready_s;
    logic [ENQ_WIDTH-1:0]            fire_s;
    logic [QUEUE_SIZE-1:0]           tail_oh_s;
    logic [ENQ_WIDTH*QUEUE_SIZE-1:0] ring_flat_s;
    logic [ENQ_WIDTH*QUEUE_SIZE-1:0] pick_flat_s;
    logic [ENQ_WIDTH*QUEUE_SIZE-1:0] slot_flat_s;
    logic [QUEUE_SIZE-1:0]           set_s;
    int unsigned                     fired_n_s;

    logic [QUEUE_SIZE-1:0]           kill_s;
    logic [QUEUE_SIZE-1:0]           rel_s;
    logic [QUEUE_SIZE-1:0]           clr_s;
    int unsigned                     released_n_s;
    int unsigned                     killed_n_s;
    int unsigned                     removed_n_s;
    logic [QUEUE_SIZE-1:0]           valid_next_s;
    logic [CNT_W-1:0]                count_next_s;
    logic [PTR_W-1:0]                head_next_s;
    logic [PTR_W-1:0]                tail_next_s;

    // Grant depends only on registered count and the flush strobe, never on release.
    assign free_s      = CNT_W'(QUEUE_SIZE) - count_r;
    assign enq_ready_s = !bus.flush && (free_s >= CNT_W'(ENQ_WIDTH));
    assign fire_s      = bus.enq_req & {ENQ_WIDTH{enq_ready_s}};
    assign tail_oh_s   = QUEUE_SIZE'(1) << tail_r;

    generate
        if (!IN_ORDER) begin : g_pick
            free_slot_pick #(.WIDTH(QUEUE_SIZE), .N(ENQ_WIDTH)) u_pick (
                .busy    (valid_r),
                .pick_oh (pick_flat_s)
            );
        end else begin : g_no_pick
            assign pick_flat_s = '0;
        end
    endgenerate

    // Ring candidates: tail one-hot rotated left by the lane index
    always_comb begin
        logic [2*QUEUE_SIZE-1:0] rot;
        rot         = '0;
        ring_flat_s = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            rot = {tail_oh_s, tail_oh_s} << i;
            ring_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE] = rot[2*QUEUE_SIZE-1 -: QUEUE_SIZE];
        end
    end

    // Per-lane slot selection, zeroed for lanes that do not fire
    always_comb begin
        slot_flat_s = '0;
        set_s       = '0;
        fired_n_s   = 32'd0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (fire_s[i]) begin
                if (IN_ORDER) begin
                    slot_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE] = ring_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE];
                end else begin
                    slot_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE] = pick_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE];
                end
                set_s     = set_s | slot_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE];
                fired_n_s = fired_n_s + 32'd1;
            end else begin
                slot_flat_s[i*QUEUE_SIZE +: QUEUE_SIZE] = '0;
            end
        end
    end

    // Next occupancy, count and pointers; a slot in both masks is removed once
    always_comb begin
        kill_s       = bus.flush ? bus.flush_kill : '0;
        rel_s        = bus.deq_release & valid_r;
        clr_s        = (rel_s | kill_s) & valid_r;
        released_n_s = popcount(MAX_QUEUE_SIZE'(rel_s));
        killed_n_s   = popcount(MAX_QUEUE_SIZE'(kill_s & valid_r & ~rel_s));
        removed_n_s  = popcount(MAX_QUEUE_SIZE'(clr_s));
        valid_next_s = (valid_r & ~clr_s) | set_s;
        count_next_s = CNT_W'(32'(count_r) + fired_n_s - removed_n_s);
        if (IN_ORDER) begin
            head_next_s = PTR_W'(mod_add(32'(head_r), released_n_s, QS_U));
            tail_next_s = PTR_W'(mod_sub(mod_add(32'(tail_r), fired_n_s, QS_U), killed_n_s, QS_U));
        end else begin
            head_next_s = '0;
            tail_next_s = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            valid_r <= valid_next_s;
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

    assign bus.enq_ready   = enq_ready_s;
    assign bus.enq_slot_oh = slot_flat_s;
    assign bus.valid_vec   = valid_r;
    assign bus.head_oh     = IN_ORDER ? (QUEUE_SIZE'(1) << head_r) : '0;
    assign bus.count       = count_r;
    assign bus.empty       = (count_r == CNT_W'(0));
    assign bus.full        = (count_r == CNT_W'(QUEUE_SIZE));

    iq_enq_alloc_chk #(
        .QUEUE_SIZE (QUEUE_SIZE),
        .ENQ_WIDTH  (ENQ_WIDTH),
        .IN_ORDER   (IN_ORDER),
        .PTR_W      (PTR_W),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clock       (clock),
        .reset       (reset),
        .enq_req     (bus.enq_req),
        .enq_slot_oh (slot_flat_s),
        .valid_vec   (valid_r),
        .count       (count_r),
        .deq_release (bus.deq_release),
        .flush       (bus.flush),
        .flush_kill  (bus.flush_kill),
        .head        (head_r),
        .tail        (tail_r)
    );

endmodule
